// File: rtl/n_bit_seq_shift_right.sv
// Sequential right shifter: shifts the captured operand by one bit per clock
// until the requested distance is reached. Fill is zero (logical) or the
// operand sign (arithmetic). Result stays on out until the next accepted start.
module n_bit_seq_shift_right #(
   parameter int N  = 32,
   parameter int SW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [N-1:0]  in,
   input  logic [SW-1:0] shamt,
   input  logic          arith,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [SW-1:0] count;
   logic          fill;
   logic          accept;

   // A new operation may begin only while no shift is in flight.
   assign accept = start && ((state == IDLE) || (state == DONE));

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   // Next-state decision; a zero distance goes straight to DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (shamt != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (count <= SW'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               state_next = (shamt != '0) ? SHIFT : DONE;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register; reset aborts any operation in progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Working register, remaining-distance counter and latched fill bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out   <= '0;
         count <= '0;
         fill  <= 1'b0;
      end else if (accept) begin
         out   <= in;
         count <= shamt;
         fill  <= arith & in[N-1];
      end else if (state == SHIFT) begin
         out <= {fill, out[N-1:1]};
         if (count != '0) begin
            count <= count - SW'(1);
         end
      end
   end

endmodule

// File: doc/n_bit_seq_shift_right.md
N_BIT_SEQ_SHIFT_RIGHT -- requirements
Module: n_bit_seq_shift_right

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning data width in bits (N >= 2).
REQ-002 The block SHALL have parameter SW, default 5, meaning shift-amount width; the integrator SHALL set 2^SW = N.
REQ-003 The block SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-low, sampled on the rising edge of clk.
REQ-005 The block SHALL have port start, input, 1 bit, request to begin a shift operation.
REQ-006 The block SHALL have port in, input, N bits, operand captured on accepted start.
REQ-007 The block SHALL have port shamt, input, SW bits, shift distance captured on accepted start.
REQ-008 The block SHALL have port arith, input, 1 bit, captured on accepted start: 1 = arithmetic (sign fill), 0 = logical (zero fill).
REQ-009 The block SHALL have port busy, output, 1 bit, high while an operation is in progress (state SHIFT).
REQ-010 The block SHALL have port done, output, 1 bit, single-cycle pulse marking out valid.
REQ-011 The block SHALL have port out, output, N bits, shift result register.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE; busy = (state == SHIFT); done = (state == DONE).
REQ-013 Start SHALL be accepted only on an edge where state is IDLE or DONE and rst is high; start in SHIFT SHALL be ignored with no effect.
REQ-014 On acceptance: working register loaded with in, counter loaded with shamt, fill bit latched as arith AND in[N-1]; next state SHIFT if shamt != 0, DONE if shamt == 0.
REQ-015 Each edge in SHIFT SHALL shift the working register right by exactly one bit, inserting the latched fill bit at bit N-1, and decrement the counter by 1.
REQ-016 On the SHIFT edge where the counter equals 1, the next state SHALL be DONE; otherwise SHIFT is held.
REQ-017 DONE SHALL last exactly one cycle; next state is SHIFT/DONE per REQ-014 if start is accepted, else IDLE.
REQ-018 Latency: for start accepted at edge k, done SHALL be high in the cycle following edge k+shamt (shamt+1 cycles after the start cycle); shamt = 0 gives done one cycle after start.
REQ-019 out SHALL equal the working register; result SHALL equal in >> shamt (logical) or the signed arithmetic shift (arith = 1) when done is high.
REQ-020 out SHALL hold its value in IDLE and DONE until the next accepted start reloads it.
REQ-021 Inputs in, shamt, arith SHALL be ignored except on the accepting edge; changes during SHIFT SHALL not affect the result.
REQ-022 Maximum shamt (N-1) SHALL complete in N-1 SHIFT cycles; the counter SHALL never wrap below 0.

Reset
REQ-023 When rst is low at a rising edge: state = IDLE, out = 0, counter = 0, fill = 0, busy = 0, done = 0.
REQ-024 Reset SHALL take priority over start and abort any operation in progress with no done pulse.
REQ-025 After rst returns high, the first accepted start SHALL behave identically to start from power-up.

Verification
REQ-026 Logical: N=32, in=0x80000010, shamt=4, arith=0 -> busy 4 cycles, done 5 cycles after start, out=0x08000001.
REQ-027 Arithmetic: in=0x80000010, shamt=4, arith=1 -> out=0xF8000001; in=0x7FFFFFFF, shamt=31, arith=1 -> out=0x00000000 after 31 busy cycles.
REQ-028 Zero shift: in=0xDEADBEEF, shamt=0 -> busy never high, done one cycle after start, out=0xDEADBEEF.
REQ-029 Back-to-back: start held high in DONE with new in=0xFFFFFFFF, shamt=8, arith=0 -> second operation accepted without IDLE cycle, out=0x00FFFFFF.
REQ-030 Ignored start/inputs: during SHIFT pulse start and change in/shamt -> result and latency of the original operation unchanged.
REQ-031 Reset mid-operation: rst low on the 3rd SHIFT cycle -> next cycle state IDLE, out=0, busy=0, no done pulse.
